fix2float_pipe: RTL and testbench

//  - 3-stage pipelined signed fixed-point (Q(32-FRAC_BITS).FRAC_BITS) to IEEE-754 single converter.
//  - Consumes the leading-zero count of the operand magnitude from an internal clz32 instance (a[31:0] -> z[5:0]).
//  - Feeds float-domain raytracing stages with coordinates and intersection distances.
//  - Valid/ready handshake on both sides; full throughput, 1 result/cycle, when unstalled.

---
 rtl/fix2float_pipe.sv | 109 ++++++++++
 tb/tb_fix2float_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fix2float_pipe.sv
// Three-stage signed fixed-point to IEEE-754 single converter with valid/ready flow control.
// Define FIX2FLOAT_RNE_EN for round-to-nearest-even; otherwise the result is truncated toward zero.

module clz32 (
   input  logic [31:0] i_a,
   output logic [5:0]  o_z
);
   always_comb begin
      // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
      o_z = 6'd32;
      for (int i = 0; i < 32; i++) begin
         if (i_a[i]) o_z = 6'(31 - i);
      end
   end
endmodule

module fix2float_pipe #(
   parameter int FRAC_BITS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data
);

`ifdef FIX2FLOAT_RNE_EN
   localparam int NORM_LSB = 0;
`else
   localparam int NORM_LSB = 8;
`endif
   localparam int NORM_W = 32 - NORM_LSB;
   // Biased exponent is 158 - FRAC_BITS - z, always within 96..158, so 8 bits suffice.
   localparam logic [7:0] EXP_BASE = 8'(158 - FRAC_BITS);

   logic                r_v1, r_v2, r_v3;
   logic                r_s1_sign;
   logic [31:0]         r_s1_mag;
   logic                r_s2_sign;
   logic [31:NORM_LSB]  r_s2_norm;
   logic [7:0]          r_s2_exp;
   logic [31:0]         r_out;

   logic                w_go1, w_go2, w_go3;
   logic [5:0]          w_z;
   logic [23:0]         w_mant;
   logic [7:0]          w_exp;
   logic [31:0]         w_pack;

   // A stage can load when it is empty or its contents move on this cycle.
   assign w_go3     = ~r_v3 | out_ready;
   assign w_go2     = ~r_v2 | w_go3;
   assign w_go1     = ~r_v1 | w_go2;
   assign in_ready  = w_go1;
   assign out_valid = r_v3;
   assign out_data  = r_out;

   clz32 u_clz (
      .i_a (r_s1_mag),
      .o_z (w_z)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         r_v1  <= 1'b0;
         r_v2  <= 1'b0;
         r_v3  <= 1'b0;
         r_out <= 32'h0;
      end else begin
         if (w_go1) r_v1 <= in_valid;
         if (w_go2) r_v2 <= r_v1;
         if (w_go3) begin
            r_v3 <= r_v2;
            if (r_v2) r_out <= w_pack;
         end
      end
   end

   // NOTE: datapath registers carry no reset; their contents are ignored until the matching valid bit is set.
   always_ff @(posedge clk) begin
      if (w_go1 && in_valid) begin
         r_s1_sign <= in_data[31];
         r_s1_mag  <= in_data[31] ? -in_data : in_data;
      end
      if (w_go2 && r_v1) begin
         r_s2_sign <= r_s1_sign;
         r_s2_norm <= NORM_W'((r_s1_mag << w_z) >> NORM_LSB);
         r_s2_exp  <= EXP_BASE - {2'b00, w_z};
      end
   end

   always_comb begin
`ifdef FIX2FLOAT_RNE_EN
      w_mant = {1'b0, r_s2_norm[30:8]}
             + {23'h0, r_s2_norm[7] & ((|r_s2_norm[6:0]) | r_s2_norm[8])};
`else
      w_mant = {1'b0, r_s2_norm[30:8]};
`endif
      // A mantissa carry-out leaves w_mant[22:0] at zero and bumps the exponent.
      w_exp  = r_s2_exp + {7'h0, w_mant[23]};
      // The normalized MSB is clear only for a zero operand, which packs as +0.
      w_pack = r_s2_norm[31] ? {r_s2_sign, w_exp, w_mant[22:0]} : 32'h0;
   end

endmodule

// File: tb/tb_fix2float_pipe.sv
// Directed and randomized checks of fix2float_pipe with FRAC_BITS = 16.
// Expected values follow FIX2FLOAT_RNE_EN in the same way the design does.

module tb_fix2float_pipe;
   localparam int FRAC = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;

   int n_cmp = 0;
   int n_mis = 0;

   fix2float_pipe #(.FRAC_BITS(FRAC)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   // Drive one cycle's inputs at the falling edge and report the handshakes that the next rising edge will complete.
   task automatic tick(input logic v, input logic [31:0] d, input logic r,
                       output logic acc, output logic emit, output logic [31:0] q);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      #1;
      acc  = v & in_ready;
      emit = out_valid & r;
      q    = out_data;
   endtask

   // Independent model: locate the MSB, shift to 24 bits, round on the dropped remainder.
   function automatic logic [31:0] ref_f2f(input logic [31:0] x);
      logic        s;
      logic [63:0] mag, m;
      int          p, ex;
`ifdef FIX2FLOAT_RNE_EN
      logic [63:0] rem, half;
`endif
      s   = x[31];
      mag = {32'h0, s ? (~x + 32'd1) : x};
      if (mag == 64'h0) return 32'h0;
      p = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) p = i;
      ex = 127 + p - FRAC;
      if (p <= 23) begin
         m = mag << (23 - p);
      end else begin
         m = mag >> (p - 23);
`ifdef FIX2FLOAT_RNE_EN
         rem  = mag & ((64'd1 << (p - 23)) - 64'd1);
         half = 64'd1 << (p - 24);
         if (rem > half || (rem == half && m[0])) m = m + 64'd1;
`endif
      end
      if (m[24]) begin
         m  = m >> 1;
         ex = ex + 1;
      end
      return {s, ex[7:0], m[22:0]};
   endfunction

   task automatic test_reset;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++;
      if (out_data !== 32'h0) begin n_mis++; $display("FAIL reset_out_data: got %h want 00000000", out_data); end
      n_cmp++;
      if (in_ready !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_vectors;
      logic [31:0] vin [9];
      logic [31:0] vexp[9];
      logic acc, emit, got;
      logic [31:0] q;
      int n;
      vin[0] = 32'h00010000; vexp[0] = 32'h3F800000;
      vin[1] = 32'hFFFF0000; vexp[1] = 32'hBF800000;
      vin[2] = 32'h00000000; vexp[2] = 32'h00000000;
      vin[3] = 32'h80000000; vexp[3] = 32'hC7000000;
      vin[4] = 32'h00008000; vexp[4] = 32'h3F000000;
      vin[5] = 32'h00000001; vexp[5] = 32'h37800000;
      vin[6] = 32'h01000001; vexp[6] = 32'h43800000;
`ifdef FIX2FLOAT_RNE_EN
      vin[7] = 32'h7FFFFFFF; vexp[7] = 32'h47000000;
      vin[8] = 32'h01000003; vexp[8] = 32'h43800002;
`else
      vin[7] = 32'h7FFFFFFF; vexp[7] = 32'h46FFFFFF;
      vin[8] = 32'h01000003; vexp[8] = 32'h43800001;
`endif
      for (int k = 0; k < 9; k++) begin
         tick(1'b1, vin[k], 1'b1, acc, emit, q);
         n_cmp++;
         if (acc !== 1'b1) begin n_mis++; $display("FAIL vec%0d_accept: got %b want 1", k, acc); end
         n   = 0;
         got = 1'b0;
         while (!got && n < 10) begin
            tick(1'b0, 32'h0, 1'b1, acc, emit, q);
            n++;
            if (emit) got = 1'b1;
         end
         n_cmp++;
         if (n !== 3) begin n_mis++; $display("FAIL vec%0d_latency: got %0d cycles want 3", k, n); end
         n_cmp++;
         if (q !== vexp[k]) begin n_mis++; $display("FAIL vec%0d_data: in %h got %h want %h", k, vin[k], q, vexp[k]); end
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] vals[5];
      logic [31:0] exps[5];
      logic acc, emit;
      logic [31:0] q;
      int n_acc, si, oi, t;
      vals[0] = 32'h00010000; exps[0] = 32'h3F800000;
      vals[1] = 32'h00020000; exps[1] = 32'h40000000;
      vals[2] = 32'h00030000; exps[2] = 32'h40400000;
      vals[3] = 32'h00040000; exps[3] = 32'h40800000;
      vals[4] = 32'h00050000; exps[4] = 32'h40A00000;
      n_acc = 0;
      for (int k = 0; k < 5; k++) begin
         tick(1'b1, vals[n_acc < 5 ? n_acc : 0], 1'b0, acc, emit, q);
         if (acc) n_acc++;
      end
      n_cmp++;
      if (n_acc !== 3) begin n_mis++; $display("FAIL bp_accepted: got %0d want 3", n_acc); end
      n_cmp++;
      if (in_ready !== 1'b0) begin n_mis++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'h3F800000) begin
         n_mis++; $display("FAIL bp_hold: got valid %b data %h want 1 3F800000", out_valid, out_data);
      end
      si = n_acc;
      oi = 0;
      t  = 0;
      while (oi < 5 && t < 30) begin
         tick(si < 5, vals[si < 5 ? si : 0], 1'b1, acc, emit, q);
         if (acc) si++;
         if (emit) begin
            n_cmp++;
            if (q !== exps[oi]) begin n_mis++; $display("FAIL bp_out%0d: got %h want %h", oi, q, exps[oi]); end
            oi++;
         end
         t++;
      end
      n_cmp++;
      if (oi !== 5) begin n_mis++; $display("FAIL bp_count: got %0d outputs want 5", oi); end
   endtask

   task automatic test_reset_midflight;
      logic acc, emit;
      logic [31:0] q;
      int n_emit;
      tick(1'b1, 32'h00070000, 1'b1, acc, emit, q);
      tick(1'b1, 32'h00090000, 1'b1, acc, emit, q);
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_mis++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
      n_emit = 0;
      for (int k = 0; k < 10; k++) begin
         tick(1'b0, 32'h0, 1'b1, acc, emit, q);
         if (emit) n_emit++;
      end
      n_cmp++;
      if (n_emit !== 0) begin n_mis++; $display("FAIL midrst_leak: got %0d outputs want 0", n_emit); end
   endtask

   task automatic test_random;
      logic [31:0] sb[$];
      logic [31:0] d, want;
      logic acc, emit, v, r;
      logic [31:0] q;
      int n_in, t;
      n_in = 0;
      t    = 0;
      d    = $urandom;
      v    = 1'b0;
      while ((n_in < 10000 || sb.size() != 0) && t < 80000) begin
         if (!v) begin
            case ($urandom_range(0, 3))
               0: d = $urandom;
               1: d = $urandom >> $urandom_range(0, 31);
               2: d = -($urandom >> $urandom_range(0, 31));
               default: d = ($urandom_range(0, 1) == 0) ? 32'h80000000 : 32'h7FFFFFFF - 32'($urandom_range(0, 300));
            endcase
            v = (n_in < 10000) && ($urandom_range(0, 9) < 7);
         end
         r = ($urandom_range(0, 9) < 7) || n_in >= 10000;
         tick(v, d, r, acc, emit, q);
         if (acc) begin
            sb.push_back(ref_f2f(d));
            n_in++;
            v = 1'b0;
         end
         if (emit) begin
            want = (sb.size() != 0) ? sb.pop_front() : 32'hDEADBEEF;
            n_cmp++;
            if (q !== want) begin n_mis++; $display("FAIL rand_out: got %h want %h", q, want); end
         end
         t++;
      end
      n_cmp++;
      if (n_in !== 10000 || sb.size() !== 0) begin
         n_mis++; $display("FAIL rand_drain: accepted %0d pending %0d want 10000 0", n_in, sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_backpressure();
      test_reset_midflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
